// File: rtl/reaction_pkg.sv
// Shared definitions for the reaction-timer blocks: FSM state encoding,
// LFSR seed/taps and the polarity of the subject's response button.
package reaction_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        ARMED = 2'd2,
        DONE  = 2'd3
    } state_t;

    // 16-bit Fibonacci LFSR, taps 16,14,13,11 -> register bits 15,13,12,10.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // The response button pulls detect low when pressed.
    localparam logic DETECT_PRESSED = 1'b0;

    // One shift of the LFSR: shift left, feed the tap parity into bit 0.
    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/reaction_stimulus_if.sv
// Board-facing signal bundle of reaction_stimulus.
// slave  : the stimulus block (samples tick/start/detect, drives the rest).
// master : whatever drives the block (board glue or a testbench).
// Inputs are plain levels/pulses sampled on the rising clock edge; there is
// no back-pressure: tick_ms is a one-cycle enable, start is acted on at its
// rising edge, detect is active low.
interface reaction_stimulus_if
    import reaction_pkg::*;
#(
    parameter int DELAY_W = 12
);
    logic               tick_ms;
    logic               start;
    logic               detect;
    logic               trigger;
    logic               busy;
    logic               false_start;
    logic [DELAY_W-1:0] delay_ms;
    state_t             state;   // debug: current FSM state
    logic [15:0]        lfsr;    // debug: current LFSR value

    modport slave (
        input  tick_ms, start, detect,
        output trigger, busy, false_start, delay_ms, state, lfsr
    );

    modport master (
        output tick_ms, start, detect,
        input  trigger, busy, false_start, delay_ms, state, lfsr
    );
endinterface

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11), seeded on reset.
// Shared with the display-blanking logic.
module lfsr16
    import reaction_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    output logic [15:0] lfsr
);

    // Advance one step every clock; reset reloads the seed.
    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= lfsr_next(lfsr);
        end
    end

endmodule

// File: rtl/reaction_stimulus.sv
// Stimulus side of the reaction timer: on a start edge wait a pseudo-random
// number of milliseconds, raise trigger, drop it when the subject responds.
// Optional feature: define RSTIM_FALSE_START_EN to flag and abort a trial
// when the subject presses during the random wait (false_start).
module reaction_stimulus
    import reaction_pkg::*;
#(
    parameter int MIN_DELAY_MS = 1000,
    parameter int RAND_BITS    = 11,
    parameter int DELAY_W      = 12
) (
    input  logic                 clock,
    input  logic                 reset,
    reaction_stimulus_if.slave   bus
);

    state_t             state;
    logic               start_q;
    logic               trigger_q;
    logic               busy_q;
    logic [DELAY_W-1:0] count;
    logic [DELAY_W-1:0] delay_q;
    logic [15:0]        lfsr_q;
    logic               start_edge;
    logic               pressed;
    logic [DELAY_W-1:0] delay_load;

    lfsr16 u_lfsr (
        .clock (clock),
        .reset (reset),
        .lfsr  (lfsr_q)
    );

    assign start_edge = bus.start && !start_q;
    assign pressed    = (bus.detect == DETECT_PRESSED);
    // Fixed floor plus the low LFSR bits, drawn at the moment of the start edge.
    assign delay_load = DELAY_W'(MIN_DELAY_MS) + DELAY_W'(lfsr_q[RAND_BITS-1:0]);

`ifdef RSTIM_FALSE_START_EN
    logic false_start_q;
    assign bus.false_start = false_start_q;
`else
    assign bus.false_start = 1'b0;
`endif

    // Trial FSM, countdown, start-edge register and all registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            start_q   <= 1'b0;
            trigger_q <= 1'b0;
            busy_q    <= 1'b0;
            count     <= '0;
            delay_q   <= '0;
`ifdef RSTIM_FALSE_START_EN
            false_start_q <= 1'b0;
`endif
        end else begin
            start_q <= bus.start;
            case (state)
                IDLE, DONE: begin
                    // A start with the button already held is not a valid trial.
                    if (start_edge && !pressed) begin
                        count     <= delay_load;
                        delay_q   <= delay_load;
                        state     <= WAIT;
                        busy_q    <= 1'b1;
                        trigger_q <= 1'b0;
`ifdef RSTIM_FALSE_START_EN
                        false_start_q <= 1'b0;
`endif
                    end
                end
                WAIT: begin
`ifdef RSTIM_FALSE_START_EN
                    if (pressed) begin
                        // Anticipated response: abandon the countdown.
                        false_start_q <= 1'b1;
                        state         <= DONE;
                        busy_q        <= 1'b0;
                        trigger_q     <= 1'b0;
                    end else
`endif
                    if (bus.tick_ms && count != '0) begin
                        count <= count - 1'b1;
                        if (count == DELAY_W'(1)) begin
                            state     <= ARMED;
                            trigger_q <= 1'b1;
                        end
                    end
                end
                ARMED: begin
                    if (pressed) begin
                        trigger_q <= 1'b0;
                        busy_q    <= 1'b0;
                        state     <= DONE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    busy_q    <= 1'b0;
                    trigger_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.trigger  = trigger_q;
    assign bus.busy     = busy_q;
    assign bus.delay_ms = delay_q;
    assign bus.state    = state;
    assign bus.lfsr     = lfsr_q;

endmodule

// File: tb/tb_reaction_stimulus.sv
// Bench for reaction_stimulus with MIN_DELAY_MS=5, RAND_BITS=3, DELAY_W=4 and
// one tick_ms every 4 clocks. Build with +define+RSTIM_FALSE_START_EN to
// exercise the false-start variant.
module tb_reaction_stimulus;
    import reaction_pkg::*;

    localparam int MIN = 5;
    localparam int RB  = 3;
    localparam int DW  = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    reaction_stimulus_if #(.DELAY_W(DW)) bus ();

    reaction_stimulus #(
        .MIN_DELAY_MS (MIN),
        .RAND_BITS    (RB),
        .DELAY_W      (DW)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int fails  = 0;
    int tick_ph;

    // Reference LFSR sequence: x^16+x^14+x^13+x^11 Fibonacci, seed ACE1.
    logic [15:0] m_lfsr;
    always @(posedge clock) begin
        if (reset) m_lfsr <= 16'hACE1;
        else       m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    // Millisecond tick: one-cycle pulse every 4 clocks.
    initial begin
        bus.tick_ms = 1'b0;
        tick_ph = 0;
        forever begin
            @(posedge clock);
            #1;
            tick_ph = (tick_ph + 1) % 4;
            bus.tick_ms = (tick_ph == 3);
        end
    end

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic test_reset();
        reset = 1'b1; bus.start = 1'b0; bus.detect = 1'b1;
        repeat (3) step();
        checks++; if (bus.trigger !== 1'b0) begin fails++; $display("FAIL reset_trigger: got %0d expected 0", bus.trigger); end
        checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0d expected 0", bus.busy); end
        checks++; if (bus.delay_ms !== '0) begin fails++; $display("FAIL reset_delay: got %0d expected 0", bus.delay_ms); end
        checks++; if (bus.state !== IDLE) begin fails++; $display("FAIL reset_state: got %0d expected %0d", bus.state, IDLE); end
        checks++; if (bus.false_start !== 1'b0) begin fails++; $display("FAIL reset_false_start: got %0d expected 0", bus.false_start); end
        checks++; if (bus.lfsr !== 16'hACE1) begin fails++; $display("FAIL reset_lfsr: got %h expected ace1", bus.lfsr); end
        reset = 1'b0;
        step();
    endtask

    // Issue a valid start and check the WAIT entry; returns the expected delay.
    task automatic begin_trial(output int d);
        int exp_d;
        repeat ($urandom_range(0, 7)) step();
        exp_d = MIN + int'(m_lfsr[RB-1:0]);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        checks++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL start_busy: got %0d expected 1", bus.busy); end
        checks++; if (bus.state !== WAIT) begin fails++; $display("FAIL start_state: got %0d expected %0d", bus.state, WAIT); end
        checks++; if (int'(bus.delay_ms) !== exp_d) begin fails++; $display("FAIL start_delay: got %0d expected %0d", bus.delay_ms, exp_d); end
        checks++; if (bus.delay_ms < MIN || bus.delay_ms > MIN + 7) begin fails++; $display("FAIL delay_range: got %0d expected 5..12", bus.delay_ms); end
        checks++; if (bus.trigger !== 1'b0) begin fails++; $display("FAIL start_trigger: got %0d expected 0", bus.trigger); end
        checks++; if (bus.false_start !== 1'b0) begin fails++; $display("FAIL start_false_start: got %0d expected 0", bus.false_start); end
        d = exp_d;
    endtask

    // Count ticks after WAIT entry until trigger rises; optionally pulse start mid-wait.
    task automatic wait_trigger(input int d, input bit second_start);
        int  cnt = 0;
        bit  t;
        bit  pulsed = 0;
        bit  seen = 0;
        for (int i = 0; i < 400; i++) begin
            if (second_start && !pulsed && cnt == 2) begin
                bus.start = 1'b1;
                pulsed = 1;
            end
            t = bus.tick_ms;
            step();
            bus.start = 1'b0;
            if (t) cnt++;
            if (bus.trigger === 1'b1) begin seen = 1; break; end
        end
        checks++; if (!seen) begin fails++; $display("FAIL trigger_timeout: got 0 expected 1"); end
        checks++; if (cnt !== d) begin fails++; $display("FAIL trigger_latency: got %0d ticks expected %0d", cnt, d); end
        checks++; if (bus.state !== ARMED) begin fails++; $display("FAIL armed_state: got %0d expected %0d", bus.state, ARMED); end
        checks++; if (int'(bus.delay_ms) !== d) begin fails++; $display("FAIL armed_delay: got %0d expected %0d", bus.delay_ms, d); end
    endtask

    // Hold in ARMED for a random while, then press detect.
    task automatic respond(input int d);
        int n = $urandom_range(0, 5);
        bit held = 1;
        for (int i = 0; i < n; i++) begin
            step();
            if (bus.trigger !== 1'b1) held = 0;
        end
        checks++; if (!held) begin fails++; $display("FAIL armed_hold: got 0 expected 1"); end
        bus.detect = 1'b0;
        step();
        bus.detect = 1'b1;
        checks++; if (bus.trigger !== 1'b0) begin fails++; $display("FAIL resp_trigger: got %0d expected 0", bus.trigger); end
        checks++; if (bus.state !== DONE) begin fails++; $display("FAIL resp_state: got %0d expected %0d", bus.state, DONE); end
        checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL resp_busy: got %0d expected 0", bus.busy); end
        checks++; if (int'(bus.delay_ms) !== d) begin fails++; $display("FAIL resp_delay: got %0d expected %0d", bus.delay_ms, d); end
    endtask

    task automatic test_start_ignored();
        bus.detect = 1'b0;
        bus.start  = 1'b1;
        step();
        checks++; if (bus.state !== IDLE) begin fails++; $display("FAIL ignore_state: got %0d expected %0d", bus.state, IDLE); end
        checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL ignore_busy: got %0d expected 0", bus.busy); end
        bus.start  = 1'b0;
        bus.detect = 1'b1;
        step();
    endtask

    task automatic test_basic();
        int d;
        begin_trial(d);
        wait_trigger(d, 1'b0);
        respond(d);
    endtask

    task automatic test_second_start();
        int d;
        begin_trial(d);
        wait_trigger(d, 1'b1);
        respond(d);
    endtask

    task automatic test_back_to_back();
        int d;
        for (int k = 0; k < 6; k++) begin
            begin_trial(d);
            wait_trigger(d, 1'b0);
            respond(d);
        end
    endtask

    task automatic test_false_start();
        int d;
        int cnt = 0;
        bit t;
        bit seen = 0;
        begin_trial(d);
        // Run until the 2nd tick of WAIT is about to be sampled, press then.
        for (int i = 0; i < 400; i++) begin
            t = bus.tick_ms;
            if (t && cnt == 1) bus.detect = 1'b0;
            step();
            bus.detect = 1'b1;
            if (t) cnt++;
            if (cnt == 2) break;
        end
`ifdef RSTIM_FALSE_START_EN
        checks++; if (bus.false_start !== 1'b1) begin fails++; $display("FAIL fs_flag: got %0d expected 1", bus.false_start); end
        checks++; if (bus.state !== DONE) begin fails++; $display("FAIL fs_state: got %0d expected %0d", bus.state, DONE); end
        checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL fs_busy: got %0d expected 0", bus.busy); end
        for (int i = 0; i < d * 4 + 8; i++) begin
            step();
            if (bus.trigger === 1'b1) seen = 1;
        end
        checks++; if (seen) begin fails++; $display("FAIL fs_trigger: got 1 expected 0"); end
        checks++; if (bus.false_start !== 1'b1) begin fails++; $display("FAIL fs_sticky: got %0d expected 1", bus.false_start); end
        begin_trial(d);   // checks false_start cleared on the new start
        wait_trigger(d, 1'b0);
        respond(d);
`else
        for (int i = 0; i < 400; i++) begin
            if (bus.trigger === 1'b1) begin seen = 1; break; end
            t = bus.tick_ms;
            step();
            if (t) cnt++;
        end
        checks++; if (!seen) begin fails++; $display("FAIL nofs_timeout: got 0 expected 1"); end
        checks++; if (cnt !== d) begin fails++; $display("FAIL nofs_latency: got %0d ticks expected %0d", cnt, d); end
        checks++; if (bus.false_start !== 1'b0) begin fails++; $display("FAIL nofs_flag: got %0d expected 0", bus.false_start); end
        respond(d);
`endif
    endtask

    task automatic test_reset_mid_trial();
        int d;
        begin_trial(d);
        wait_trigger(d, 1'b0);
        repeat ($urandom_range(0, 3)) step();
        reset = 1'b1;
        step();
        checks++; if (bus.trigger !== 1'b0) begin fails++; $display("FAIL mid_reset_trigger: got %0d expected 0", bus.trigger); end
        checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL mid_reset_busy: got %0d expected 0", bus.busy); end
        checks++; if (bus.delay_ms !== '0) begin fails++; $display("FAIL mid_reset_delay: got %0d expected 0", bus.delay_ms); end
        checks++; if (bus.state !== IDLE) begin fails++; $display("FAIL mid_reset_state: got %0d expected %0d", bus.state, IDLE); end
        reset = 1'b0;
        checks++; if (bus.lfsr !== 16'hACE1) begin fails++; $display("FAIL mid_reset_lfsr: got %h expected ace1", bus.lfsr); end
        begin_trial(d);
        wait_trigger(d, 1'b0);
        respond(d);
    endtask

    initial begin
        bus.start  = 1'b0;
        bus.detect = 1'b1;
        test_reset();
        test_start_ignored();
        test_basic();
        test_second_start();
        test_back_to_back();
        test_false_start();
        test_reset_mid_trial();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
